// File: rtl/sub16_if.sv
// sub16_if: operand/result bundle for the registered signed subtractor.
interface sub16_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_sticky;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             borrow;
    logic             ovf_sticky;
    modport master (
        output in_valid, a, b, clr_sticky,
        input  out_valid, result, overflow, zero, negative, borrow, ovf_sticky
    );
    modport slave (
        input  in_valid, a, b, clr_sticky,
        output out_valid, result, overflow, zero, negative, borrow, ovf_sticky
    );
endinterface

// File: rtl/sub16_signed.sv
// sub16_signed: registered A - B with signed overflow, status flags and sticky overflow.
module sub16_signed #(parameter int WIDTH = 16) (
    input logic   clk,
    input logic   rst_n,
    sub16_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    logic [WIDTH-1:0] nb, r;
    logic             ovf;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;
    logic             borrow_d, borrow_q;
    logic             ovf_sticky_d, ovf_sticky_q;
    // Overflow is that of A + (-B); with B = most-negative this reduces to A[MSB].
    always_comb begin
        nb           = ~bus.b + 1'b1;
        r            = bus.a + nb;
        ovf          = (bus.a[MSB] == nb[MSB]) && (r[MSB] != bus.a[MSB]);
        out_valid_d  = bus.in_valid;
        result_d     = bus.in_valid ? r : result_q;
        overflow_d   = bus.in_valid ? ovf : overflow_q;
        zero_d       = bus.in_valid ? (r == '0) : zero_q;
        negative_d   = bus.in_valid ? r[MSB] : negative_q;
        borrow_d     = bus.in_valid ? (bus.a < bus.b) : borrow_q;
        ovf_sticky_d = (bus.in_valid && ovf) ? 1'b1 : bus.clr_sticky ? 1'b0 : ovf_sticky_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
            negative_q   <= 1'b0;
            borrow_q     <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            zero_q       <= zero_d;
            negative_q   <= negative_d;
            borrow_q     <= borrow_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = negative_q;
    assign bus.borrow     = borrow_q;
    assign bus.ovf_sticky = ovf_sticky_q;
endmodule

// File: tb/tb_sub16_signed.sv
// tb_sub16_signed: directed vectors against an integer reference of the subtractor.
module tb_sub16_signed;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic        e_valid, e_ovf, e_zero, e_neg, e_borrow, e_sticky;
    logic [15:0] e_res;
    sub16_if bus ();
    sub16_signed dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Drive one cycle, advance the reference, compare packed {valid,result,ovf,zero,neg,borrow,sticky}.
    task automatic step(input int a, input int b, input logic v, input logic clr, input string tag);
        int          diff;
        logic        ovf;
        logic [15:0] ua, ub;
        ua = a[15:0];
        ub = b[15:0];
        bus.a = ua;
        bus.b = ub;
        bus.in_valid = v;
        bus.clr_sticky = clr;
        @(posedge clk);
        #1;
        diff = $signed(ua) - $signed(ub);
        ovf  = ($signed(ub) == -32768) ? ($signed(ua) < 0) : (diff > 32767 || diff < -32768);
        if (!rst_n) begin
            {e_valid, e_res, e_ovf, e_zero, e_neg, e_borrow, e_sticky} = '0;
        end else begin
            e_valid = v;
            if (v) begin
                e_res    = diff[15:0];
                e_ovf    = ovf;
                e_zero   = (diff[15:0] == 16'd0);
                e_neg    = diff[15];
                e_borrow = (ua < ub);
            end
            e_sticky = (v && ovf) ? 1'b1 : clr ? 1'b0 : e_sticky;
        end
        check(tag, {10'd0, bus.out_valid, bus.result, bus.overflow, bus.zero, bus.negative, bus.borrow, bus.ovf_sticky},
                   {10'd0, e_valid, e_res, e_ovf, e_zero, e_neg, e_borrow, e_sticky});
    endtask
    int grid [9] = '{0, 1, -1, 32767, -32768, 32766, -32767, 16384, -16384};
    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.clr_sticky = 1'b0;
        step(5, 3, 1'b1, 1'b1, "reset0");
        step(5, 3, 1'b1, 1'b0, "reset1");
        rst_n = 1'b1;
        step(5, 3, 1'b1, 1'b0, "post_reset");
        check("post_reset_res", {16'd0, bus.result}, 32'd2);
        foreach (grid[i]) foreach (grid[j]) step(grid[i], grid[j], 1'b1, 1'b0, "grid");
        step(0, -32768, 1'b1, 1'b0, "bmin_a0");
        check("bmin_a0_lit", {13'd0, bus.result, bus.overflow, bus.borrow, bus.zero}, {13'd0, 16'h8000, 3'b010});
        step(-1, -32768, 1'b1, 1'b0, "bmin_am1");
        check("bmin_am1_lit", {13'd0, bus.result, bus.overflow, bus.borrow, bus.zero}, {13'd0, 16'h7fff, 3'b100});
        step(-32768, -32768, 1'b1, 1'b0, "bmin_amin");
        check("bmin_amin_lit", {13'd0, bus.result, bus.overflow, bus.borrow, bus.zero}, {13'd0, 16'h0000, 3'b101});
        step(0, 0, 1'b0, 1'b1, "clear");
        step(10, 20, 1'b1, 1'b0, "hold_load");
        check("hold_load_lit", {13'd0, bus.result, bus.negative, bus.borrow, bus.out_valid}, {13'd0, 16'hfff6, 3'b111});
        step(7, 7, 1'b0, 1'b0, "hold_idle");
        check("hold_idle_lit", {15'd0, bus.result, bus.out_valid}, {15'd0, 16'hfff6, 1'b0});
        step(32767, -1, 1'b1, 1'b0, "sticky_set");
        check("sticky_set_lit", {31'd0, bus.ovf_sticky}, 32'd1);
        step(1, 2, 1'b1, 1'b0, "sticky_hold0");
        step(100, 50, 1'b1, 1'b0, "sticky_hold1");
        step(-5, 5, 1'b1, 1'b0, "sticky_hold2");
        check("sticky_held_lit", {31'd0, bus.ovf_sticky}, 32'd1);
        step(0, 0, 1'b0, 1'b1, "sticky_clr");
        check("sticky_clr_lit", {31'd0, bus.ovf_sticky}, 32'd0);
        step(-32768, 1, 1'b1, 1'b1, "sticky_set_wins");
        check("sticky_wins_lit", {31'd0, bus.ovf_sticky}, 32'd1);
        step(1000, 1, 1'b1, 1'b0, "b2b0");
        step(-200, 300, 1'b1, 1'b0, "b2b1");
        step(12345, 12345, 1'b1, 1'b0, "b2b2");
        step(-16384, 16385, 1'b1, 1'b0, "b2b3");
        rst_n = 1'b0;
        step(4, 1, 1'b1, 1'b0, "midreset");
        rst_n = 1'b1;
        step(4, 1, 1'b0, 1'b0, "after_midreset");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sub16_signed.md
Name: sub16_signed

Overview:
Registered two's-complement subtractor computing result = A - B, with a signed-overflow flag and companion status flags. Single-cycle latency with a valid qualifier. Used as a datapath arithmetic primitive behind a register stage. Adds a sticky overflow indicator for software/monitor polling.

Parameters:
WIDTH, 16, operand/result width in bits (all requirements below are written for WIDTH=16; bit 15 = MSB = WIDTH-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  A/B valid this cycle; capture and compute
A  input  16  signed minuend
B  input  16  signed subtrahend
clr_sticky  input  1  clears ovf_sticky
out_valid  output  1  result/flags updated this cycle (registered in_valid)
result  output  16  signed A - B, modulo 2^16
overflow  output  1  signed overflow flag for the captured operation
zero  output  1  result == 0
negative  output  1  result[15]
borrow  output  1  unsigned A < B
ovf_sticky  output  1  set by any valid overflow, held until cleared

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst_n=0; all outputs go to 0 (out_valid, result, overflow, zero, negative, borrow, ovf_sticky). Reset overrides in_valid and clr_sticky. Reset mid-operation discards the in-flight operation; out_valid=0 on the next cycle.
- Latency: 1 cycle. Operands applied with in_valid=1 before edge N appear on result/flags after edge N, with out_valid=1 for that cycle.
- out_valid <= in_valid every non-reset cycle.
- in_valid=0: result, overflow, zero, negative, borrow hold their previous values; out_valid=0.
- Arithmetic: nb = (~B + 1) truncated to 16 bits; r = (A + nb) truncated to 16 bits; result = r (bit-identical to A - B mod 2^16; no saturation, wrap-around).
- overflow = (A[15] == nb[15]) AND (r[15] != A[15]). This is overflow of the addition A + nb, and it is normative including the B = -32768 case. There nb = -32768, so overflow = A[15]. Examples: 0 - (-32768) gives result -32768, overflow 0; -1 - (-32768) gives result 32767, overflow 1. For every other B it equals true signed-subtraction overflow.
- zero = (r == 0); negative = r[15]; borrow = 1 when unsigned A < unsigned B (no carry out of A + ~B + 1).
- ovf_sticky: on a non-reset edge, set to 1 when in_valid=1 and the computed overflow = 1; otherwise cleared to 0 when clr_sticky=1; otherwise held. A simultaneous set and clear leaves it at 1 (set wins).
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, A=5, B=3 for 2 edges -> all outputs 0. Release rst_n -> next edge gives result=2, out_valid=1, flags 0.
- Full grid: A,B each over {0, 1, -1, 32767, -32768, 32766, -32767, 16384, -16384} (81 pairs, in_valid=1) -> one cycle later result = A-B mod 2^16 and overflow per the rule above. Examples: 32767-(-1) gives -32768, ovf 1; -32768-1 gives 32767, ovf 1; 16384-(-16384) gives -32768, ovf 1; 1-1 gives 0, zero 1, ovf 0.
- B=-32768 corner: A=0 -> result -32768, overflow 0, borrow 1. A=-1 -> result 32767, overflow 1, borrow 0. A=-32768 -> result 0, zero 1, overflow 1.
- Hold/valid: apply A=10, B=20, in_valid=1 -> result=-10, negative=1, borrow=1. Next cycle A=7, B=7 with in_valid=0 -> outputs unchanged, out_valid=0.
- Sticky: 32767-(-1) valid -> ovf_sticky=1. Then 3 non-overflow ops -> stays 1. clr_sticky=1 alone -> 0. clr_sticky=1 concurrent with overflowing op -> remains 1.
- Back-to-back: in_valid=1 on consecutive cycles with changing operands -> each result appears exactly one cycle later and out_valid stays continuously 1.
